// File: rtl/fifo_rr_drain_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_drain_arbiter_if
// Brief    : FIFO-bank and output-stream signal bundle for the drain arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rr_drain_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int W_SRC = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       fifo_empty_i;
  logic [N*WIDTH-1:0] fifo_data_i;
  logic [N-1:0]       fifo_rd_en_o;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [WIDTH-1:0]   m_data_o;
  logic [W_SRC-1:0]   m_src_o;
  logic               busy_o;

  // master: the arbiter itself; slave: the FIFO bank plus downstream consumer
  modport master (
    input  fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, m_src_o, busy_o
  );
  modport slave (
    output fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, m_src_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_drain_arbiter
// Brief    : Round-robin drain of N show-ahead FIFOs into one valid/ready
//            stream, up to BURST words per grant, source-tagged output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_drain_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fifo_rr_drain_arbiter_if.master bus
);
  localparam int W_SRC = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  localparam int         STATE_W = 1;
  localparam logic [STATE_W-1:0] S_IDLE  = 1'b0;
  localparam logic [STATE_W-1:0] S_GRANT = 1'b1;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [W_SRC-1:0]   r_last_grant;
  logic [W_SRC-1:0]   r_grant;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [W_SRC-1:0]   r_src;

  logic               w_found;
  logic [W_SRC-1:0]   w_search_idx;
  logic               w_load;
  logic               w_grant_empty;
  logic               w_pop;
  logic               w_release;
  logic [WIDTH-1:0]   w_head;

  // Scan downward so the lowest offset from last_grant wins.
  always_comb begin
    logic [W_SRC-1:0] v_idx;
    w_found      = 1'b0;
    w_search_idx = '0;
    for (int k = N; k >= 1; k--) begin
      v_idx = W_SRC'((int'(r_last_grant) + k) % N);
      if (!bus.fifo_empty_i[v_idx]) begin
        w_found      = 1'b1;
        w_search_idx = v_idx;
      end
    end
  end

  assign w_load        = ~r_valid | bus.m_ready_i;
  assign w_grant_empty = bus.fifo_empty_i[r_grant];
  assign w_pop         = (r_state == S_GRANT) & w_load & ~w_grant_empty & ~rst_i;
  assign w_release     = (r_state == S_GRANT) &
                         ((w_pop & (r_burst_cnt == CNT_W'(BURST - 1))) | w_grant_empty);
  assign w_head        = bus.fifo_data_i[int'(r_grant) * WIDTH +: WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= W_SRC'(N - 1);
      r_grant      <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && w_found) begin
        r_grant     <= w_search_idx;
        r_burst_cnt <= '0;
      end
      if (w_pop) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
      if (w_release) begin
        r_last_grant <= r_grant;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found)   w_next_state = S_GRANT;
      S_GRANT: if (w_release) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // Output register only advances when empty or being consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_load) begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_data  <= w_head;
        r_src   <= r_grant;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.fifo_rd_en_o = '0;
    if (w_pop) begin
      bus.fifo_rd_en_o[r_grant] = 1'b1;
    end
    bus.busy_o    = (r_state == S_GRANT);
    bus.m_valid_o = r_valid;
    bus.m_data_o  = r_data;
    bus.m_src_o   = r_src;
  end
endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_drain_arbiter
// Brief    : Directed bench with FIFO-bank model and service-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_drain_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_drain_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  fifo_rr_drain_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fq [N][$];
  int         exp_src [$];
  logic [7:0] exp_dat [$];
  int         acc_src [$];
  logic [7:0] acc_dat [$];
  int         m_last = N - 1;
  logic [N-1:0] rd_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    logic [N-1:0]       e;
    logic [N*WIDTH-1:0] d;
    e = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      e[i] = (fq[i].size() == 0);
      if (!e[i]) d[i*WIDTH +: WIDTH] = fq[i][0];
    end
    bus.fifo_empty_i = e;
    bus.fifo_data_i  = d;
  endtask

  task automatic load(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) fq[i].push_back(base + 8'(k));
    refresh();
  endtask

  // Expected service order from the arbitration rules alone: next non-empty
  // FIFO after the previous one, min(BURST, remaining) words per visit.
  task automatic build_sched();
    int pos [N];
    int ptr, found, take, c;
    for (int i = 0; i < N; i++) pos[i] = 0;
    ptr = m_last;
    while (1) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        c = (ptr + k) % N;
        if (found < 0 && pos[c] < fq[c].size()) found = c;
      end
      if (found < 0) break;
      take = 0;
      while (take < BURST && pos[found] < fq[found].size()) begin
        exp_src.push_back(found);
        exp_dat.push_back(fq[found][pos[found]]);
        pos[found]++;
        take++;
      end
      ptr = found;
    end
    m_last = ptr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rd_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    chk("rst_valid", bus.m_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rst = 1'b0;
    exp_src.delete();
    exp_dat.delete();
    m_last = N - 1;
    build_sched();
  endtask

  task automatic drain(input bit pattern);
    int t = 0;
    while ((exp_src.size() != 0 || !all_empty() || bus.m_valid_o || bus.busy_o) && t < 600) begin
      bus.m_ready_i = pattern ? (t % 3 != 2) : 1'b1;
      tick();
      t++;
    end
    bus.m_ready_i = 1'b1;
    chk("drain_timeout", t < 600, 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.m_valid_o && t < 20) begin
      tick();
      t++;
    end
    chk("wait_valid_timeout", bus.m_valid_o, 1);
  endtask

  // Per-cycle compare process, sampled on the falling edge.
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_d = '0;
  logic [1:0] prev_s = '0;
  always @(negedge clk) begin
    rd_s = bus.fifo_rd_en_o;
    if (rst) begin
      chk("rst_rd_en", bus.fifo_rd_en_o, 0);
      if (prev_rst) begin
        chk("rst_hold_valid", bus.m_valid_o, 0);
        chk("rst_hold_busy", bus.busy_o, 0);
      end
    end else begin
      chk("rd_onehot", $countones(bus.fifo_rd_en_o) <= 1, 1);
      chk("pop_on_empty", |(bus.fifo_rd_en_o & bus.fifo_empty_i), 0);
      if (!prev_rst && prev_v && !prev_r) begin
        chk("stall_valid", bus.m_valid_o, 1);
        chk("stall_data", bus.m_data_o, prev_d);
        chk("stall_src", bus.m_src_o, prev_s);
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        acc_src.push_back(int'(bus.m_src_o));
        acc_dat.push_back(bus.m_data_o);
        chk("sb_has_word", exp_src.size() != 0, 1);
        if (exp_src.size() != 0) begin
          chk("sb_src", bus.m_src_o, exp_src.pop_front());
          chk("sb_data", bus.m_data_o, exp_dat.pop_front());
        end
      end
    end
    prev_v   = bus.m_valid_o;
    prev_r   = bus.m_ready_i;
    prev_rst = rst;
    prev_d   = bus.m_data_o;
    prev_s   = bus.m_src_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ev, eb;
    bus.m_ready_i = 1'b1;
    refresh();

    // Reset with every FIFO loaded, then a full rotation.
    for (int i = 0; i < N; i++) load(i, 4, 8'(16 * i));
    do_reset(3);
    acc_src.delete(); acc_dat.delete();
    drain(1'b0);
    chk("rot_count", acc_src.size(), 16);
    for (int j = 0; j < 16 && j < acc_src.size(); j++) begin
      chk("rot_src", acc_src[j], (j / 2) % 4);
      chk("rot_data", acc_dat[j], 16 * ((j / 2) % 4) + (j / 8) * 2 + (j % 2));
    end
    tick(); tick();

    // Single requester: FIFO 2 holds A0..A2.
    load(2, 3, 8'hA0);
    build_sched();
    ev = 6'b010110;
    eb = 6'b011011;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("single_valid", bus.m_valid_o, ev[k]);
      chk("single_busy", bus.busy_o, eb[k]);
      if (k == 1) begin chk("single_d0", bus.m_data_o, 8'hA0); chk("single_s0", bus.m_src_o, 2); end
      if (k == 2) begin chk("single_d1", bus.m_data_o, 8'hA1); chk("single_s1", bus.m_src_o, 2); end
      if (k == 4) begin chk("single_d2", bus.m_data_o, 8'hA2); chk("single_s2", bus.m_src_o, 2); end
    end
    drain(1'b0);
    tick();

    // Backpressure after the first word of a burst.
    load(1, 4, 8'hB0);
    build_sched();
    wait_valid();
    bus.m_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", bus.m_valid_o, 1);
      chk("bp_data", bus.m_data_o, 8'hB0);
      chk("bp_src", bus.m_src_o, 1);
      chk("bp_rd_en", rd_s, 0);
      chk("bp_busy", bus.busy_o, 1);
    end
    bus.m_ready_i = 1'b1;
    tick();
    chk("bp_resume_data", bus.m_data_o, 8'hB1);
    chk("bp_release", bus.busy_o, 0);
    drain(1'b0);
    tick();

    // Reset while an output word is stalled.
    load(3, 4, 8'hC0);
    load(1, 2, 8'hD0);
    build_sched();
    wait_valid();
    chk("mid_first_src", bus.m_src_o, 3);
    bus.m_ready_i = 1'b0;
    tick();
    do_reset(1);
    bus.m_ready_i = 1'b1;
    acc_src.delete(); acc_dat.delete();
    drain(1'b0);
    chk("mid_count", acc_src.size(), 5);
    if (acc_src.size() > 0) begin
      chk("mid_next_src", acc_src[0], 1);
      chk("mid_next_data", acc_dat[0], 8'hD0);
    end

    // Early release on a single-word FIFO, with intermittent ready.
    do_reset(1);
    load(0, 4, 8'hE0);
    load(1, 1, 8'hF0);
    load(2, 4, 8'h20);
    load(3, 4, 8'h30);
    build_sched();
    acc_src.delete(); acc_dat.delete();
    drain(1'b1);
    chk("early_count", acc_src.size(), 13);
    if (acc_src.size() >= 4) begin
      chk("early_s0", acc_src[0], 0);
      chk("early_s1", acc_src[1], 0);
      chk("early_s2", acc_src[2], 1);
      chk("early_s3", acc_src[3], 2);
      chk("early_d2", acc_dat[2], 8'hF0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Drains N show-ahead FIFOs into one valid/ready output stream using round-robin arbitration.
- Each grant covers at most BURST words. The grant is released early if the granted FIFO runs empty.
- Generates the per-FIFO read enables and tags each output word with its source index.
- Sits between a bank of per-requester FIFOs and a single shared downstream consumer.

Parameters:
- N, 4, number of requester FIFOs (>=1).
- WIDTH, 8, data width of every FIFO and of the output.
- BURST, 2, maximum words popped per grant (>=1).
- W_SRC (local), max(1, $clog2(N)), source index width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- fifo_empty_i  in  N  empty flag of FIFO i.
- fifo_data_i  in  N*WIDTH  show-ahead head word of FIFO i, at bits [i*WIDTH +: WIDTH]; valid when fifo_empty_i[i]=0.
- fifo_rd_en_o  out  N  pop strobe to FIFO i; at most one bit high per cycle.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream accepts the word when m_valid_o && m_ready_i.
- m_data_o  out  WIDTH  output word.
- m_src_o  out  W_SRC  index of the FIFO the word came from.
- busy_o  out  1  high while in GRANT state.

Behaviour:
- Reset state:
  - state=IDLE, last_grant=N-1 (so the first search starts at index 0), burst_cnt=0.
  - m_valid_o=0; m_data_o=0 and m_src_o=0 (registered, cleared); fifo_rd_en_o=0; busy_o=0.
- Output register:
  - load = ~m_valid_o | m_ready_i.
  - On pop: m_data_o<=fifo_data_i[grant], m_src_o<=grant, m_valid_o<=1.
  - On load without pop: m_valid_o<=0.
  - While m_valid_o=1 && m_ready_i=0, data and source hold stable.
- IDLE:
  - Search indices last_grant+1 ... last_grant+N (mod N) for the first with fifo_empty_i=0.
  - If one is found: grant<=index, burst_cnt<=0, go to GRANT. No pop occurs in IDLE.
  - If all are empty: stay in IDLE.
- GRANT:
  - pop = load & ~fifo_empty_i[grant]; fifo_rd_en_o[grant]=pop; all other enables are 0.
  - burst_cnt increments on each pop. It freezes under backpressure.
  - Release condition: (pop & burst_cnt==BURST-1) OR fifo_empty_i[grant]=1.
  - On release: last_grant<=grant, go to IDLE.
  - An empty-triggered release happens in the first cycle the granted FIFO is observed empty; no pop occurs that cycle.
- Latency and throughput:
  - A word appears on m_data_o one cycle after its pop.
  - Arbitration costs one bubble cycle per grant (the IDLE cycle).
  - Peak throughput is BURST/(BURST+1) words per cycle.
- Fairness: a FIFO just served is searched last. With all FIFOs non-empty, service order is 0,1,...,N-1,0,...
- N=1: search always returns 0; behaviour is otherwise identical.
- BURST=1: release on every pop.
- Reset mid-burst:
  - Any held output word is discarded (m_valid_o=0).
  - No pop is issued in the reset cycle.
  - Arbitration restarts from index 0.
- Never pops a FIFO whose empty flag is high.
- Never pops more than one FIFO per cycle.
- Never overwrites an unaccepted output word.

Test Plan:
- Reset: hold rst_i 3 cycles with all FIFOs non-empty -> fifo_rd_en_o=0, m_valid_o=0, busy_o=0 throughout; first grant after release goes to FIFO 0.
- Single requester (N=4, BURST=2, m_ready_i=1): only FIFO 2 holds A0,A1,A2. Required m_data_o/m_src_o sequence:
  - A0/2, A1/2;
  - then 1 bubble cycle (m_valid_o=0);
  - then A2/2;
  - then FIFO 2 empty -> release, return to IDLE.
- Full rotation: all four FIFOs hold 4 words each, m_ready_i=1 -> source sequence 0,0,1,1,2,2,3,3,0,0,1,1,... with one bubble between grants; all 16 words delivered, in per-FIFO order.
- Backpressure: drop m_ready_i for 5 cycles after the first word of a burst -> m_data_o/m_src_o stable, fifo_rd_en_o=0, burst_cnt frozen; on resume the second word follows with no loss or duplication.
- Early release: FIFO 1 holds 1 word, FIFOs 0, 2 and 3 hold 4 each -> grants 0 (2 words), 1 (1 word, released on empty), then 2 (2 words); FIFO 1 is never popped while empty.
- Reset mid-burst: assert rst_i while m_valid_o=1 and m_ready_i=0 -> next cycle m_valid_o=0, state IDLE; the next grant goes to the lowest-index non-empty FIFO.
